fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the async FIFO write port among NREQ producers
//   i_clk/i_rst        write clock, synchronous active-high reset
//   i_req/i_data       per-requester beat valid and data (requester k at [k*DSIZE +: DSIZE])
//   o_ack              beat from requester k accepted this cycle
//   o_grant/o_busy     registered one-hot grant and burst-in-progress flag
//   o_wr/o_wdata       FIFO write strobe and data; i_wfull stalls the burst
//   o_beat_cnt         per-requester saturating beat counters, present only with ARB_STATS_EN
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*DSIZE-1:0] i_data,
    output logic [NREQ-1:0]       o_ack,
    output logic [NREQ-1:0]       o_grant,
    output logic                  o_busy,
    output logic                  o_wr,
    output logic [DSIZE-1:0]      o_wdata,
`ifdef ARB_STATS_EN
    output logic [NREQ*16-1:0]    o_beat_cnt,
`endif
    input  logic                  i_wfull
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t          state_q, state_d;
    logic [IW-1:0]   gidx_q, gidx_d, last_q, last_d, pick;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_d;
    logic            found, last_beat;
    // a beat sampled together with reset is dropped so the requester re-presents it
    assign o_ack     = o_grant & i_req & {NREQ{!i_wfull && !i_rst}};
    assign o_wr      = |o_ack;
    assign o_busy    = state_q == BURST;
    assign o_wdata   = o_busy ? i_data[gidx_q*DSIZE +: DSIZE] : '0;
    assign last_beat = o_wr && cnt_q == CW'(MAX_BURST - 1);
    // first requester above the last winner, wrapping around
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && i_req[IW'((int'(last_q) + i) % NREQ)]) begin
                found = 1'b1;
                pick  = IW'((int'(last_q) + i) % NREQ);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        grant_d = o_grant;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = o_wr ? cnt_q + CW'(1) : cnt_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = BURST;
                grant_d = NREQ'(1) << pick;
                gidx_d  = pick;
                cnt_d   = '0;
            end
        end else if (!i_req[gidx_q] || last_beat) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = gidx_q;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            o_grant <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            o_grant <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
`ifdef ARB_STATS_EN
    logic [15:0] beat_cnt [NREQ];
    for (genvar k = 0; k < NREQ; k++) begin : g_stat
        always_ff @(posedge i_clk) begin
            if (i_rst)
                beat_cnt[k] <= '0;
            else if (o_ack[k] && beat_cnt[k] != 16'hFFFF)
                beat_cnt[k] <= beat_cnt[k] + 16'd1;
        end
        assign o_beat_cnt[k*16 +: 16] = beat_cnt[k];
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAX_BURST=4)
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0, rst = 1'b1, wfull = 1'b0, busy, wr;
    logic [3:0]  req = 4'hF, ack, grant, ack_s;
    logic [31:0] data;
    logic [7:0]  wdata;
`ifdef ARB_STATS_EN
    logic [63:0] beat_cnt;
`endif
    int          vecs = 0, errs = 0;
    int          dcnt [4] = '{default: 0};
    int          en   [4] = '{default: 0};
    logic [11:0] sbq [$];
    logic [11:0] e;
    bit          sb_on = 1'b1;

    fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAX_BURST(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
        .o_ack(ack), .o_grant(grant), .o_busy(busy), .o_wr(wr), .o_wdata(wdata),
`ifdef ARB_STATS_EN
        .o_beat_cnt(beat_cnt),
`endif
        .i_wfull(wfull)
    );

    always #5 clk = ~clk;

    // producers: requester k presents k*16 + beats already acked, advancing only on ack
    always_comb begin
        data = '0;
        for (int k = 0; k < 4; k++) data[k*8 +: 8] = 8'(k*16 + dcnt[k]);
    end
    initial forever begin
        @(negedge clk);
        ack_s = ack;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) if (ack_s[k]) dcnt[k]++;
    end

    // monitor: every FIFO write must match the next expected beat
    always @(negedge clk) begin
        if (sb_on && wr) begin
            vecs++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL sb_unexpected: got grant=%b data=%h, expected no write", grant, wdata);
            end else begin
                e = sbq.pop_front();
                if ({grant, wdata} !== e || ack !== grant) begin
                    errs++;
                    $display("FAIL sb_beat: got grant=%b ack=%b data=%h, expected grant=ack=%b data=%h",
                             grant, ack, wdata, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", n, got, exp);
        end
    endtask

    task automatic push(int k, int nb);
        repeat (nb) begin
            sbq.push_back({4'(1 << k), 8'(k*16 + en[k])});
            en[k]++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // reset held with all requests asserted
        repeat (2) begin
            cyc();
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
            chk("rst_wr", wr, 0);
        end
        rst = 1'b0;
        // round robin 0,1,2,3,0 with four beats each and one bubble between
        push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
        cyc();
        for (int c = 0; c < 25; c++) begin
            chk("rr_grant", grant, (c % 5 == 4) ? 0 : (1 << ((c / 5) % 4)));
            if (c == 24) req = '0;
            cyc();
        end
        chk("rr_drain", sbq.size(), 0);
`ifdef ARB_STATS_EN
        chk("stats_rr", beat_cnt, {16'd4, 16'd4, 16'd4, 16'd8});
`endif
        // early release by requester 0 after two beats
        do_reset();
        req = 4'b0011;
        push(0, 2); push(1, 4);
        cyc();
        chk("er_first", grant, 4'b0001);
        cyc();
        cyc();
        req = 4'b0010;
        chk("er_hold", grant, 4'b0001);
        cyc();
        chk("er_release", grant, 0);
        cyc();
        chk("er_next", grant, 4'b0010);
        repeat (4) cyc();
        req = '0;
        chk("er_bubble", grant, 0);
        cyc();
        chk("er_drain", sbq.size(), 0);
        // FIFO full for five cycles after the first beat
        do_reset();
        req = 4'b0001;
        push(0, 4);
        cyc();
        cyc();
        wfull = 1'b1;
        repeat (5) begin
            #1;
            chk("full_wr", wr, 0);
            chk("full_ack", ack, 0);
            chk("full_grant", grant, 4'b0001);
            cyc();
        end
        wfull = 1'b0;
        repeat (3) cyc();
        req = '0;
        chk("full_end", grant, 0);
        cyc();
        chk("full_drain", sbq.size(), 0);
        // reset in the middle of a requester 2 burst
        do_reset();
        req = 4'b0100;
        push(2, 2); push(0, 4); push(2, 4);
        cyc();
        chk("rm_grant2", grant, 4'b0100);
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("rm_wr_dropped", wr, 0);
        cyc();
        rst = 1'b0;
        req = 4'b0101;
        chk("rm_idle_grant", grant, 0);
        chk("rm_idle_busy", busy, 0);
        cyc();
        chk("rm_restart0", grant, 4'b0001);
        repeat (4) cyc();
        req = 4'b0100;
        chk("rm_bubble", grant, 0);
        cyc();
        chk("rm_regrant2", grant, 4'b0100);
        repeat (4) cyc();
        req = '0;
        chk("rm_end", grant, 0);
        cyc();
        chk("rm_drain", sbq.size(), 0);
`ifdef ARB_STATS_EN
        // long single-requester run drives the counter into saturation
        do_reset();
        sb_on = 1'b0;
        req = 4'b0010;
        repeat (87505) @(posedge clk);
        #1;
        req = '0;
        chk("stats_sat", beat_cnt[31:16], 16'hFFFF);
        chk("stats_other", {beat_cnt[63:32], beat_cnt[15:0]}, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
